// File: rtl/eql_rr_arbiter.sv
// Round-robin arbiter sharing the b06 eql/cont_eql request port among NREQ requesters.
// Optional BUSY timeout abort is enabled with `define EQL_ARB_TIMEOUT_EN.
module eql_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] cont,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            eql,
  output logic            cont_eql,
  input  logic            ackout
);

  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_chk
    $error("eql_rr_arbiter: NREQ must be 2..8 and TIMEOUT 2..255");
  end

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            eql_q, eql_d;
  logic            cont_eql_q, cont_eql_d;

`ifdef EQL_ARB_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
`endif

  // Winner: first set request scanning upward from ptr+1, wrapping at NREQ.
  logic [PW-1:0] win;
  logic [PW-1:0] scan_idx;
  logic          found;
  always_comb begin
    win      = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    eql_d      = eql_q;
    cont_eql_d = cont_eql_q;
`ifdef EQL_ARB_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_BUSY;
          ptr_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          eql_d      = 1'b1;
          cont_eql_d = cont[win];
`ifdef EQL_ARB_TIMEOUT_EN
          tcnt_d     = '0;
`endif
        end
      end
      S_BUSY: begin
        // Acknowledge has priority over a timeout landing in the same cycle.
        if (ackout) begin
          done_d     = gnt_q;
          gnt_d      = '0;
          eql_d      = 1'b0;
          cont_eql_d = 1'b0;
          state_d    = S_REL;
        end
`ifdef EQL_ARB_TIMEOUT_EN
        else if (tcnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          gnt_d      = '0;
          eql_d      = 1'b0;
          cont_eql_d = 1'b0;
          state_d    = S_REL;
        end else if (tcnt_q != TMO_MAX) begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      eql_q      <= 1'b0;
      cont_eql_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      eql_q      <= eql_d;
      cont_eql_q <= cont_eql_d;
    end
  end

`ifdef EQL_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign eql      = eql_q;
  assign cont_eql = cont_eql_q;

endmodule

// File: tb/tb_eql_rr_arbiter.sv
// Scoreboard bench for eql_rr_arbiter: expected grants queued at stimulus time, popped on grant rise.
module tb_eql_rr_arbiter;
  localparam int NREQ = 4;

  logic            clock, reset, ackout;
  logic [NREQ-1:0] req, cont, gnt, done;
  logic            err, eql, cont_eql;

  int n_chk = 0;
  int n_err = 0;
  logic [NREQ:0] exp_q[$];   // {cont_eql, gnt}
  logic [NREQ-1:0] prev_gnt;

  eql_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req(req), .cont(cont), .gnt(gnt),
    .done(done), .err(err), .eql(eql), .cont_eql(cont_eql), .ackout(ackout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < 40) begin
      tick();
      n++;
    end
    if (gnt == '0) chk("gnt_wait_expired", 0, 1);
  endtask

  // Grant-rise monitor: every new grant must match the head of the scoreboard.
  always @(negedge clock) begin
    chk("gnt_onehot", 32'($onehot0(gnt)), 1);
    if (gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) chk("gnt_unexpected", {cont_eql, gnt}, 0);
      else chk("gnt_order", {cont_eql, gnt}, exp_q.pop_front());
    end
    prev_gnt = gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    prev_gnt = '0;
    reset = 1'b0; req = '0; cont = '0; ackout = 1'b0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_eql", eql, 0);
    chk("rst_cont_eql", cont_eql, 0);
    reset = 1'b1;
    tick();

    // ackout while idle must not produce anything
    ackout = 1'b1;
    repeat (3) tick();
    chk("idle_ack_gnt", gnt, 0);
    chk("idle_ack_done", done, 0);
    ackout = 1'b0;
    tick();

    // Asynchronous reset in the middle of a transaction
    exp_q.push_back({1'b0, 4'b0010});
    req = 4'b0010;
    wait_gnt(n);
    chk("mid_gnt", gnt, 4'b0010);
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_done", done, 0);
    chk("async_err", err, 0);
    chk("async_eql", eql, 0);
    chk("async_cont_eql", cont_eql, 0);
    req = '0;
    tick();
    chk("async_no_done", done, 0);
    reset = 1'b1;
    tick();

    // Fairness: all requesting, ack one cycle after each grant
    req  = 4'b1111;
    cont = 4'b1010;
    exp_q.push_back({1'b0, 4'b0001});
    exp_q.push_back({1'b1, 4'b0010});
    exp_q.push_back({1'b0, 4'b0100});
    exp_q.push_back({1'b1, 4'b1000});
    exp_q.push_back({1'b0, 4'b0001});
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      if (k > 0) chk("rr_gap", n, 2);
      ackout = 1'b1;
      tick();
      ackout = 1'b0;
      chk("rr_done", done, 4'b0001 << (k % 4));
      chk("rr_eql_low", eql, 0);
      if (k == 4) begin req = '0; cont = '0; end
    end

    // Single requester, ack raised three cycles after eql
    exp_q.push_back({1'b1, 4'b0100});
    req  = 4'b0100;
    cont = 4'b0100;
    wait_gnt(n);
    for (int i = 0; i < 3; i++) begin
      chk("sr_gnt", gnt, 4'b0100);
      chk("sr_cont", cont_eql, 1);
      chk("sr_eql", eql, 1);
      if (i < 2) tick();
    end
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("sr_done", done, 4'b0100);
    chk("sr_gnt_off", gnt, 0);
    chk("sr_eql_off", eql, 0);
    chk("sr_cont_off", cont_eql, 0);
    req = '0; cont = '0;
    tick();
    chk("sr_done_pulse", done, 0);
    chk("sr_eql_gap1", eql, 0);
    tick();
    chk("sr_eql_gap2", eql, 0);

    // Withdrawal during BUSY, then next set bit after 1, then re-request wrap
    exp_q.push_back({1'b0, 4'b0010});
    exp_q.push_back({1'b0, 4'b1000});
    exp_q.push_back({1'b0, 4'b0001});
    req = 4'b0010;
    wait_gnt(n);
    tick();
    req = 4'b1001;
    tick();
    chk("wd_hold", gnt, 4'b0010);
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("wd_done", done, 4'b0010);
    wait_gnt(n);
    chk("wd_next", gnt, 4'b1000);
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("wd_done3", done, 4'b1000);
    wait_gnt(n);
    chk("wd_wrap", gnt, 4'b0001);
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("wd_done0", done, 4'b0001);
    req = '0;
    repeat (2) tick();

`ifdef EQL_ARB_TIMEOUT_EN
    exp_q.push_back({1'b0, 4'b0001});
    req = 4'b0001;
    wait_gnt(n);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("to_err_early", err, 0);
      chk("to_eql_held", eql, 1);
    end
    tick();
    chk("to_err", err, 1);
    chk("to_no_done", done, 0);
    chk("to_gnt_off", gnt, 0);
    chk("to_eql_off", eql, 0);
    req = '0;
    tick();
    chk("to_err_pulse", err, 0);
    tick();
    exp_q.push_back({1'b0, 4'b0001});
    req = 4'b0001;
    wait_gnt(n);
    repeat (14) tick();
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("to_ack_done", done, 4'b0001);
    chk("to_ack_noerr", err, 0);
    req = '0;
    tick();
    chk("to_ack_noerr2", err, 0);
`else
    exp_q.push_back({1'b0, 4'b0001});
    req = 4'b0001;
    wait_gnt(n);
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("noto_eql", eql, 1);
      chk("noto_err", err, 0);
    end
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("noto_done", done, 4'b0001);
    req = '0;
`endif

    repeat (4) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
